// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit common-anode 7-segment scanner.
// Segment vectors are ordered {a,b,c,d,e,f,g}; every output is active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  typedef logic [1:0] digit_idx_t;

  // One displayable frame: four hex nibbles plus their decimal points.
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
  } disp_word_t;

  // Active-low one-hot anode select for a digit.
  function automatic logic [3:0] an_select(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit scan controller with per-slot blanking gap and
// frame-aligned (tear-free) commit of newly loaded display values.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_en,
  input  logic [3:0]  digit_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int unsigned   CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;
  disp_word_t       pending_q, pending_d;
  logic             pend_q, pend_d;
  disp_word_t       shadow_q, shadow_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_done_q, frame_done_d;

  logic       slot_end;
  logic       frame_end;
  logic       in_blank;
  logic       show;
  logic [3:0] nibble;
  logic [6:0] seg_dec;
  disp_word_t load_word;

  if (BLANK_CYC == 0) begin : g_no_gap
    assign in_blank = 1'b0;
  end else begin : g_gap
    assign in_blank = (cnt_q < CNT_W'(BLANK_CYC));
  end

  assign load_word = '{value: value, dp: dp_en};
  assign nibble    = shadow_q.value[{idx_q, 2'b00} +: 4];

  seg7_hex_dec u_hex_dec (
    .hex_i (nibble),
    .seg_o (seg_dec)
  );

  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == 2'd3);

    cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d = slot_end ? idx_q + 2'd1 : idx_q;

    pending_d = pending_q;
    pend_d    = pend_q;
    shadow_d  = shadow_q;
    if (load) begin
      pending_d = load_word;
    end
    // A load landing on the boundary bypasses the pending stage entirely.
    if (frame_end) begin
      pend_d = 1'b0;
      if (load) begin
        shadow_d = load_word;
      end else if (pend_q) begin
        shadow_d = pending_q;
      end
    end else if (load) begin
      pend_d = 1'b1;
    end

    show         = !in_blank && digit_en[idx_q];
    an_d         = show ? an_select(idx_q) : AN_OFF;
    seg_d        = show ? seg_dec : SEG_BLANK;
    dp_d         = show ? ~shadow_q.dp[idx_q] : 1'b1;
    frame_done_d = frame_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pending_q    <= '0;
      pend_q       <= 1'b0;
      shadow_q     <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      pend_q       <= pend_d;
      shadow_q     <= shadow_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2.
module tb_seg7_scan_ctrl;

  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * SD;

  localparam logic [6:0] DEC_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_en;
  logic [3:0]  digit_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  seg7_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .dp_en      (dp_en),
    .digit_en   (digit_en),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected 32 samples of one frame, starting the cycle after frame_done.
  function automatic void push_frame(input logic [15:0] v, input logic [3:0] d,
                                     input logic [3:0] en);
    for (int j = 0; j < FRAME; j++) begin
      exp_t e;
      int   slot;
      int   pos;
      slot = j / SD;
      pos  = j % SD;
      if (pos < BC || !en[slot]) begin
        e.an  = 4'b1111;
        e.seg = 7'b1111111;
        e.dp  = 1'b1;
      end else begin
        e.an  = 4'b1111;
        e.an[slot] = 1'b0;
        e.seg = DEC_TAB[v[slot*4 +: 4]];
        e.dp  = ~d[slot];
      end
      e.fd = (j == FRAME - 1);
      exp_q.push_back(e);
    end
  endfunction

  task automatic check_frames(input string name, input int n);
    for (int k = 0; k < n * FRAME; k++) begin
      exp_t e;
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s[%0d]: scoreboard empty, got an=%b seg=%b", name, k, an, seg);
      end else begin
        e = exp_q.pop_front();
        if ({an, seg, dp, frame_done} !== e) begin
          errors++;
          $display("FAIL %s[%0d]: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                   name, k, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
        end
      end
    end
  endtask

  task automatic wait_fd(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < FRAME + 4 && !seen; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: frame_done not seen, got 0 want 1 within %0d cycles", name, FRAME + 4);
    end
  endtask

  task automatic check_startup(input string name);
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      checks++;
      if (e < 3) begin
        if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
          errors++;
          $display("FAIL %s edge%0d: got an=%b seg=%b dp=%b, want blank", name, e, an, seg, dp);
        end
      end else if ({an, seg, dp} !== {4'b1110, 7'b0000001, 1'b1}) begin
        errors++;
        $display("FAIL %s edge%0d: got an=%b seg=%b dp=%b, want an=1110 seg=0000001 dp=1",
                 name, e, an, seg, dp);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle: got an=%b seg=%b dp=%b fd=%b, want 1111 1111111 1 0",
                 an, seg, dp, frame_done);
      end
    end
    rst_n = 1'b1;
    check_startup("reset_release");
  endtask

  task automatic test_scan;
    load  = 1'b1;
    value = 16'h1234;
    dp_en = 4'b0100;
    push_frame(16'h1234, 4'b0100, 4'b1111);
    @(negedge clk);
    load = 1'b0;
    wait_fd("scan_wait");
    check_frames("scan", 1);
  endtask

  task automatic test_tear;
    push_frame(16'h1234, 4'b0100, 4'b1111);
    fork
      check_frames("tear", 2);
      begin
        repeat (12) @(negedge clk);
        load  = 1'b1;
        value = 16'hAAAA;
        dp_en = 4'b0000;
        push_frame(16'hAAAA, 4'b0000, 4'b1111);
        @(negedge clk);
        load = 1'b0;
      end
    join
  endtask

  task automatic test_simul;
    push_frame(16'hAAAA, 4'b0000, 4'b1111);
    fork
      check_frames("simul", 2);
      begin
        repeat (FRAME - 1) @(negedge clk);
        load  = 1'b1;
        value = 16'hF00F;
        dp_en = 4'b1001;
        push_frame(16'hF00F, 4'b1001, 4'b1111);
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (dut.pend_q !== 1'b0) begin
          errors++;
          $display("FAIL simul_pend: got pend=%b want 0", dut.pend_q);
        end
      end
    join
  endtask

  task automatic test_last_wins;
    push_frame(16'hF00F, 4'b1001, 4'b1111);
    fork
      check_frames("last_wins", 2);
      begin
        for (int j = 0; j < 22; j++) begin
          @(negedge clk);
          load  = (j == 3 || j == 10 || j == 20);
          dp_en = 4'b0000;
          if (j == 3)  value = 16'h1111;
          if (j == 10) value = 16'h2222;
          if (j == 20) begin
            value = 16'hBEEF;
            push_frame(16'hBEEF, 4'b0000, 4'b1111);
          end
        end
        load = 1'b0;
      end
    join
  endtask

  task automatic test_mask;
    digit_en = 4'b1010;
    push_frame(16'hBEEF, 4'b0000, 4'b1010);
    check_frames("mask", 1);
    digit_en = 4'b1111;
  endtask

  task automatic test_reset_mid;
    bit lit;
    lit = 1'b0;
    for (int k = 0; k < FRAME && !lit; k++) begin
      @(negedge clk);
      if (an !== 4'b1111) lit = 1'b1;
    end
    checks++;
    if (!lit) begin
      errors++;
      $display("FAIL reset_mid_wait: got an=%b, want a lit digit within %0d cycles", an, FRAME);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_async: got an=%b seg=%b dp=%b fd=%b, want 1111 1111111 1 0",
               an, seg, dp, frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_startup("reset_mid_restart");
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    value    = 16'h0000;
    dp_en    = 4'b0000;
    digit_en = 4'b1111;
    test_reset;
    test_scan;
    test_tear;
    test_simul;
    test_last_wins;
    test_mask;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit common-anode 7-segment display. It holds a 16-bit hex value and drives one digit at a time through the anode selects, at a fixed slot rate. Each digit is decoded to active-low segments, and a blanking gap between digits suppresses ghosting. A new value is committed only at a frame boundary, so a displayed frame never tears.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot; legal range is 2 or more.
BLANK_CYC, 16, cycles at the start of each slot with all anodes off; legal range is 0 to SCAN_DIV-1.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
load  input  1  one-cycle strobe that captures value and dp_en
value  input  16  hex digits; value[4i+3:4i] is shown on digit i
dp_en  input  4  decimal-point enable per digit, 1 = lit
digit_en  input  4  per-digit enable, 0 = slot stays blank
seg  output  7  {a,b,c,d,e,f,g}, active-low, registered
dp  output  1  decimal point, active-low, registered
an  output  4  anode selects, active-low; an[i] low drives digit i
frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - an=4'b1111, seg=7'b111_1111, dp=1, frame_done=0.
  - cnt=0, digit index idx=0.
  - shadow value and shadow dp are 0; pending register is 0; pend flag is 0.
- Reset asserted mid-frame blanks the outputs immediately, with no partial slot.
- Slot counter cnt runs 0..SCAN_DIV-1. When it wraps, idx increments 0→1→2→3→0.
- Frame boundary is the cycle where cnt=SCAN_DIV-1 and idx=3.
- Within a slot:
  - While cnt<BLANK_CYC, the slot is in phase BLANK: an=4'b1111, seg all 1, dp=1.
  - Otherwise the slot is in phase SHOW, unless digit_en[idx]=0:
    - an = ~(1<<idx).
    - seg = decode(shadow[4idx+3:4idx]).
    - dp = ~shadow_dp[idx].
  - If digit_en[idx]=0, the slot stays BLANK for its full length.
- Output latency: all outputs are registered from (cnt, idx), so they lag by 1 cycle.
  - After rst_n rises, the first an=4'b1110 appears on edge BLANK_CYC+1.
  - That digit stays on for SCAN_DIV-BLANK_CYC cycles.
  - At most one an bit is low in any cycle.
- With BLANK_CYC=0 there is no gap: the anodes switch directly from one digit to the next.
- Decode table, active-low, digits 0..F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
- Load handshake:
  - load=1 captures value and dp_en into the pending register and sets pend.
  - The block never stalls the requester; load is accepted every cycle.
  - Several loads within one frame: the last one wins.
- Commit:
  - At the frame boundary, if pend=1: shadow←pending and pend←0.
  - If load and the frame boundary coincide, the newly presented value goes straight to shadow and pend ends at 0.
  - The committed value is first visible on digit 0 of the next frame.
- frame_done is high for exactly the cycle after each frame boundary, i.e. once every 4·SCAN_DIV cycles.
- digit_en is sampled combinationally each cycle. Changing it mid-slot takes effect 1 cycle later.

Decomposition:
- Shared package seg7_pkg holds:
  - the segment-pattern constants (SEG_BLANK=7'h7F and the 16 hex patterns);
  - AN_OFF=4'hF;
  - the digit-index typedef (2-bit).
- One sub-module is natural: seg7_hex_dec, a combinational 4-bit to 7-bit active-low decoder implementing the table above. It is instantiated once, on the muxed nibble.

Test Plan:
- Reset/idle, with SCAN_DIV=8, BLANK_CYC=2:
  - Hold rst_n=0 for 5 cycles → an=1111, seg=1111111, dp=1, frame_done=0 throughout.
  - Release → an=1110 first appears on edge 3, with seg=0000001 (shadow 0).
- Scan sequence: load value=16'h1234, dp_en=4'b0100 at cycle 0, let 2 frames run.
  - Second frame shows an=1110 seg=1001100 (4), an=1101 seg=0000110 (3), an=1011 seg=0010010 (2) with dp=0, an=0111 seg=1001111 (1).
  - Each digit is on for 6 cycles, separated by 2 blank cycles.
- Tear-free commit: load 16'hAAAA mid-frame (idx=1).
  - The remainder of the current frame still shows the old value.
  - The next frame shows 0001000 on all digits.
  - The next frame starts on the cycle after the frame_done pulse.
- Simultaneous load and boundary: assert load=16'hF00F exactly at the frame-boundary cycle → the very next frame shows it, and pend reads 0.
- Last load wins: issue three loads (16'h1111, 16'h2222, 16'hBEEF) in one frame → the next frame shows BEEF: digit 3=1100000, digit 2=0110000, digit 1=0110000, digit 0=0111000.
- Masking and reset mid-slot:
  - digit_en=4'b1010 → an never shows 1110 or 1011.
  - Asserting rst_n=0 during a SHOW phase forces an=1111 asynchronously, without waiting for a clk edge.
